// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Latency: handshake cycle -> EXEC cycle -> rsp_valid in the following cycle (1 op / 3 cycles).
// Backpressure: no request is accepted while an op is in flight; RESP holds until rsp_ready.
module alu_rr_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_z,
  output logic             rsp_c,
  output logic             rsp_v
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_r_q, rsp_r_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_c_q, rsp_c_d;
  logic             rsp_v_q, rsp_v_d;
  logic             any_vld;
  logic             grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;
    rsp_z_d      = rsp_z_q;
    rsp_c_d      = rsp_c_q;
    rsp_v_d      = rsp_v_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    any_vld = req0_valid | req1_valid;
    // On a tie the requester that did not win last time goes first.
    grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    case (state_q)
      ST_IDLE: begin
        if (any_vld) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          alu_a_d      = grant ? req1_a  : req0_a;
          alu_b_d      = grant ? req1_b  : req0_b;
          alu_op_d     = grant ? req1_op : req0_op;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_r_d = alu_r;
        rsp_z_d = alu_z;
        rsp_c_d = alu_c;
        rsp_v_d = alu_v;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_id_q     <= 1'b0;
      rsp_r_q      <= '0;
      rsp_z_q      <= 1'b0;
      rsp_c_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_r_q      <= rsp_r_d;
      rsp_z_q      <= rsp_z_d;
      rsp_c_q      <= rsp_c_d;
      rsp_v_q      <= rsp_v_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_v     = rsp_v_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: behavioural ALU stand-in, transaction-level model, directed + random steps.
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_z, alu_c, alu_v;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_c, rsp_v;
  logic [7:0] rsp_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v)
  );

  // Returns {r[7:0], z, c, v} from plain integer arithmetic.
  function automatic logic [10:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int s, sa, sb, ss;
    logic [7:0] r;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = int'(a) + int'(b);
        ss = sa + sb;
        r = s[7:0];
        c = (s > 255);
        v = (ss > 127) || (ss < -128);
      end
      2'd1: begin
        s = int'(a) - int'(b);
        ss = sa - sb;
        r = s[7:0];
        c = (s < 0);
        v = (ss > 127) || (ss < -128);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r, (r == 8'd0), c, v};
  endfunction

  always_comb begin
    {alu_r, alu_z, alu_c, alu_v} = ref_alu(alu_a, alu_b, alu_op);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: is an op in flight, from when its response is due, and what it was.
  logic       m_busy;
  logic       m_last;
  int         m_resp_at;
  logic       m_id;
  logic [7:0] m_a, m_b;
  logic [1:0] m_op;
  int         cyc = 0;

  logic       obs_id[$];
  logic [7:0] obs_r[$];
  logic [2:0] obs_zcv[$];

  task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] o0,
                      input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] o1,
                      input logic rr);
    logic g, g_ok, exp_rv;
    logic [10:0] e;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready = rr;
    #1;
    g_ok = !m_busy && (v0 || v1);
    g = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", 16'(req0_ready), 16'(g_ok && !g));
    chk("req1_ready", 16'(req1_ready), 16'(g_ok && g));
    exp_rv = m_busy && (cyc >= m_resp_at);
    chk("rsp_valid", 16'(rsp_valid), 16'(exp_rv));
    if (exp_rv) begin
      e = ref_alu(m_a, m_b, m_op);
      chk("rsp_id", 16'(rsp_id), 16'(m_id));
      chk("rsp_r", 16'(rsp_r), 16'(e[10:3]));
      chk("rsp_zcv", 16'({rsp_z, rsp_c, rsp_v}), 16'(e[2:0]));
      chk("alu_a_hold", 16'(alu_a), 16'(m_a));
      chk("alu_b_hold", 16'(alu_b), 16'(m_b));
      chk("alu_op_hold", 16'(alu_op), 16'(m_op));
      if (rr) begin
        obs_id.push_back(rsp_id);
        obs_r.push_back(rsp_r);
        obs_zcv.push_back({rsp_z, rsp_c, rsp_v});
        m_busy = 1'b0;
      end
    end
    if (g_ok) begin
      m_busy = 1'b1;
      m_resp_at = cyc + 2;
      m_last = g;
      m_id = g;
      m_a = g ? a1 : a0;
      m_b = g ? b1 : b0;
      m_op = g ? o1 : o0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic clear_obs();
    obs_id.delete();
    obs_r.delete();
    obs_zcv.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    rst_n = 0;
    #1;
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_r", 16'(rsp_r), 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    m_busy = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    rst_n = 1;
    cyc++;
  endtask

  initial begin
    rst_n = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 0;
    m_busy = 0; m_last = 1; m_resp_at = 0; m_id = 0; m_a = 0; m_b = 0; m_op = 0;
    #2;
    chk("reset_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("reset_rsp_id", 16'(rsp_id), 16'd0);
    chk("reset_alu_op", 16'(alu_op), 16'd0);
    chk("reset_rsp_r", 16'(rsp_r), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Single ADD from requester 0.
    clear_obs();
    step(1, 8'd10, 8'd20, 2'd0, 0, 0, 0, 0, 1);
    idle(2);
    chk("t1_count", 16'(obs_r.size()), 16'd1);
    chk("t1_id", 16'(obs_id[0]), 16'd0);
    chk("t1_r", 16'(obs_r[0]), 16'd30);
    chk("t1_zcv", 16'(obs_zcv[0]), 16'd0);

    // Both requesters permanently valid: grants alternate.
    clear_obs();
    for (int i = 0; i < 12; i++)
      step(1, 8'(i), 8'd3, 2'd0, 1, 8'(i + 100), 8'd1, 2'd1, 1);
    chk("t2_count", 16'(obs_id.size()), 16'd4);
    chk("t2_id0", 16'(obs_id[0]), 16'd1);
    chk("t2_id1", 16'(obs_id[1]), 16'd0);
    chk("t2_id2", 16'(obs_id[2]), 16'd1);
    chk("t2_id3", 16'(obs_id[3]), 16'd0);

    // Requester 1 alone twice: overflow then carry.
    clear_obs();
    step(0, 0, 0, 0, 1, 8'h7F, 8'h01, 2'd0, 1);
    idle(2);
    step(0, 0, 0, 0, 1, 8'd200, 8'd100, 2'd0, 1);
    idle(2);
    chk("t3_count", 16'(obs_r.size()), 16'd2);
    chk("t3_id0", 16'(obs_id[0]), 16'd1);
    chk("t3_r0", 16'(obs_r[0]), 16'h80);
    chk("t3_zcv0", 16'(obs_zcv[0]), 16'b001);
    chk("t3_id1", 16'(obs_id[1]), 16'd1);
    chk("t3_r1", 16'(obs_r[1]), 16'd44);
    chk("t3_zcv1", 16'(obs_zcv[1]), 16'b010);

    // Response backpressure with the next op from requester 0 pending.
    clear_obs();
    step(1, 8'hAA, 8'h0F, 2'd2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'h33, 8'h44, 2'd1, 0, 0, 0, 0, 0);
    chk("t4_held_r", 16'(rsp_r), 16'h0A);
    step(1, 8'h33, 8'h44, 2'd1, 0, 0, 0, 0, 1);
    step(1, 8'h33, 8'h44, 2'd1, 0, 0, 0, 0, 1);
    idle(2);
    chk("t4_count", 16'(obs_r.size()), 16'd2);
    chk("t4_r0", 16'(obs_r[0]), 16'h0A);
    chk("t4_r1", 16'(obs_r[1]), 16'hEF);
    chk("t4_zcv1", 16'(obs_zcv[1]), 16'b010);

    // Zero flag.
    clear_obs();
    step(1, 8'd0, 8'd0, 2'd0, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 1, 8'h55, 8'h88, 2'd3, 1);
    idle(2);
    chk("t5_r0", 16'(obs_r[0]), 16'd0);
    chk("t5_zcv0", 16'(obs_zcv[0]), 16'b100);
    chk("t5_r1", 16'(obs_r[1]), 16'hDD);
    chk("t5_zcv1", 16'(obs_zcv[1]), 16'b000);

    // Reset during EXEC, then during RESP; first tie afterwards goes to requester 0.
    step(0, 0, 0, 0, 1, 8'd5, 8'd6, 2'd0, 0);
    do_reset();
    idle(3);
    step(0, 0, 0, 0, 1, 8'd7, 8'd8, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_resp_before_rst", 16'(rsp_valid), 16'd1);
    do_reset();
    clear_obs();
    step(1, 8'd1, 8'd2, 2'd0, 1, 8'd3, 8'd4, 2'd0, 1);
    idle(2);
    chk("t6_tie_id", 16'(obs_id[0]), 16'd0);
    chk("t6_tie_r", 16'(obs_r[0]), 16'd3);

    // Random traffic, including dropped valids and response backpressure.
    for (int i = 0; i < 600; i++)
      step(($urandom % 3) != 0, 8'($urandom), 8'($urandom), 2'($urandom),
           ($urandom % 3) != 0, 8'($urandom), 8'($urandom), 2'($urandom),
           ($urandom % 4) != 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
